// File: rtl/ps2_pkg.sv
// Shared PS/2 mouse definitions: command/response bytes and the sequencer
// state encoding (also decoded by the debug display).
package ps2_pkg;

    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_DISABLE = 8'hF5;
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_RESEND  = 8'hFE;
    localparam logic [7:0] RSP_ERROR   = 8'hFC;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_WAIT_TX  = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4,
        ST_FAIL     = 3'd5
    } seq_state_e;

    function automatic logic [7:0] cmd_for(input logic enable);
        return enable ? CMD_ENABLE : CMD_DISABLE;
    endfunction

endpackage

// File: rtl/ps2_mouse_cmd_sequencer_if.sv
// Control-path and PS/2 shim signals of the mouse command sequencer.
interface ps2_mouse_cmd_sequencer_if;

    logic       iStart;
    logic       iEnable;
    logic       iTxDone;
    logic       iTxError;
    logic [7:0] iRxData;
    logic       iRxValid;
    logic [7:0] oTxData;
    logic       oTxSend;
    logic       oBusy;
    logic       oDone;
    logic       oError;
    logic       oMouseEnabled;

    modport master (
        output iStart, iEnable, iTxDone, iTxError, iRxData, iRxValid,
        input  oTxData, oTxSend, oBusy, oDone, oError, oMouseEnabled
    );

    modport slave (
        input  iStart, iEnable, iTxDone, iTxError, iRxData, iRxValid,
        output oTxData, oTxSend, oBusy, oDone, oError, oMouseEnabled
    );

endinterface

// File: rtl/ps2_ack_timer.sv
// Acknowledge timeout counter: clear/enable up-counter that saturates at
// ACK_TIMEOUT-1 and flags that terminal count.
module ps2_ack_timer #(
    parameter int ACK_TIMEOUT = 2_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int            TW     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TC_VAL = TW'(ACK_TIMEOUT - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_mouse_cmd_sequencer.sv
// Host-to-mouse PS/2 command sequencer: sends enable/disable, waits for the
// mouse acknowledge and retries on resend request, transmit error or timeout.
module ps2_mouse_cmd_sequencer
    import ps2_pkg::*;
#(
    parameter int ACK_TIMEOUT = 2_000_000,
    parameter int MAX_RETRIES = 3
) (
    input  logic iClk,
    input  logic iReset,
    ps2_mouse_cmd_sequencer_if.slave bus
);

    localparam int            RW          = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

    seq_state_e    state_q, state_d;
    logic          start_q;
    logic [7:0]    cmd_q, cmd_d;
    logic          target_q, target_d;
    logic          pend_q, pend_d;
    logic          pend_en_q, pend_en_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          mouse_en_q, mouse_en_d;

    logic req;
    logic next_en;
    logic do_retry;
    logic timer_clr;
    logic timer_en;
    logic timer_tc;

    assign req       = bus.iStart & ~start_q;
    // A request seen in the DONE/FAIL cycle itself overrides the stored one.
    assign next_en   = req ? bus.iEnable : pend_en_q;
    assign timer_clr = (state_q == ST_WAIT_TX) && bus.iTxDone && !bus.iTxError;
    assign timer_en  = (state_q == ST_WAIT_ACK);

    ps2_ack_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_timer (
        .clk_i(iClk),
        .rst_i(iReset),
        .clr_i(timer_clr),
        .en_i (timer_en),
        .tc_o (timer_tc)
    );

    // NOTE: every variable gets its default before the case, so no path
    // through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        target_d   = target_q;
        pend_d     = pend_q;
        pend_en_d  = pend_en_q;
        retry_d    = retry_q;
        mouse_en_d = mouse_en_q;
        do_retry   = 1'b0;

        if (req && state_q != ST_IDLE) begin
            pend_d    = 1'b1;
            pend_en_d = bus.iEnable;
        end

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    cmd_d    = cmd_for(bus.iEnable);
                    target_d = bus.iEnable;
                    retry_d  = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: state_d = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (bus.iTxError) begin
                    do_retry = 1'b1;
                end else if (bus.iTxDone) begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // Any valid byte, even a stray one, outranks the timeout.
                if (bus.iRxValid) begin
                    case (bus.iRxData)
                        RSP_ACK:    state_d  = ST_DONE;
                        RSP_RESEND: do_retry = 1'b1;
                        RSP_ERROR:  state_d  = ST_FAIL;
                        default:    ;
                    endcase
                end else if (timer_tc) begin
                    do_retry = 1'b1;
                end
            end
            ST_DONE, ST_FAIL: begin
                if (state_q == ST_DONE) begin
                    mouse_en_d = target_q;
                end
                if (req || pend_q) begin
                    cmd_d    = cmd_for(next_en);
                    target_d = next_en;
                    pend_d   = 1'b0;
                    retry_d  = '0;
                    state_d  = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_retry) begin
            if (retry_q < RETRY_LIMIT) begin
                retry_d = retry_q + RW'(1);
                state_d = ST_SEND;
            end else begin
                state_d = ST_FAIL;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            cmd_q      <= 8'h00;
            target_q   <= 1'b0;
            pend_q     <= 1'b0;
            pend_en_q  <= 1'b0;
            retry_q    <= '0;
            mouse_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= bus.iStart;
            cmd_q      <= cmd_d;
            target_q   <= target_d;
            pend_q     <= pend_d;
            pend_en_q  <= pend_en_d;
            retry_q    <= retry_d;
            mouse_en_q <= mouse_en_d;
        end
    end

    assign bus.oTxData       = cmd_q;
    assign bus.oTxSend       = (state_q == ST_SEND);
    assign bus.oBusy         = (state_q != ST_IDLE);
    assign bus.oDone         = (state_q == ST_DONE);
    assign bus.oError        = (state_q == ST_FAIL);
    assign bus.oMouseEnabled = mouse_en_q;

endmodule

// File: tb/tb_ps2_mouse_cmd_sequencer.sv
// Bench for the PS/2 mouse command sequencer: directed scenarios followed by
// random transactions checked against an attempt-level outcome model.
module tb_ps2_mouse_cmd_sequencer;
    import ps2_pkg::*;

    localparam int ACK_TIMEOUT = 16;
    localparam int MAX_RETRIES = 3;
    localparam int WAIT_BUDGET = 100;

    logic iClk = 1'b0;
    logic iReset;

    ps2_mouse_cmd_sequencer_if bus();

    ps2_mouse_cmd_sequencer #(
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .MAX_RETRIES(MAX_RETRIES)
    ) dut (
        .iClk  (iClk),
        .iReset(iReset),
        .bus   (bus)
    );

    always #5 iClk = ~iClk;

    // Output monitor, sampled on the falling edge.
    int cyc = 0, n_send = 0, n_done = 0, n_err = 0;
    int send_cyc = 0, txdone_cyc = 0;
    always @(negedge iClk) begin
        cyc <= cyc + 1;
        if (bus.oTxSend) begin
            n_send   <= n_send + 1;
            send_cyc <= cyc;
        end
        if (bus.iTxDone) txdone_cyc <= cyc;
        if (bus.oDone)   n_done <= n_done + 1;
        if (bus.oError)  n_err  <= n_err + 1;
    end

    int n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic pulse_tx(input logic done, input logic err);
        bus.iTxDone  = done;
        bus.iTxError = err;
        step();
        bus.iTxDone  = 1'b0;
        bus.iTxError = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        bus.iRxData  = b;
        bus.iRxValid = 1'b1;
        step();
        bus.iRxValid = 1'b0;
        bus.iRxData  = 8'h00;
    endtask

    task automatic start_req(input logic en);
        bus.iEnable = en;
        bus.iStart  = 1'b1;
        step();
        bus.iStart  = 1'b0;
    endtask

    task automatic wait_send(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < WAIT_BUDGET && !found; i++) begin
            if (bus.oTxSend) found = 1'b1;
            else step();
        end
        check(tag, found, 1'b1);
    endtask

    // 0 = nothing within budget, 1 = oDone, 2 = oError
    task automatic wait_result(output int res);
        res = 0;
        for (int i = 0; i < WAIT_BUDGET && res == 0; i++) begin
            if (bus.oDone)       res = 1;
            else if (bus.oError) res = 2;
            else                 step();
        end
    endtask

    task automatic send_and_txdone(input string tag, input logic [7:0] exp_cmd);
        wait_send({tag, "_send"});
        check({tag, "_cmd"}, bus.oTxData, exp_cmd);
        step();
        pulse_tx(1'b1, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_txdata"}, bus.oTxData, 8'h00);
        check({tag, "_txsend"}, bus.oTxSend, 1'b0);
        check({tag, "_busy"},   bus.oBusy,   1'b0);
        check({tag, "_done"},   bus.oDone,   1'b0);
        check({tag, "_error"},  bus.oError,  1'b0);
        check({tag, "_mouse"},  bus.oMouseEnabled, 1'b0);
    endtask

    initial begin
        int   res, s0, d0, e0;
        logic model_mouse;

        bus.iStart   = 1'b0;
        bus.iEnable  = 1'b0;
        bus.iTxDone  = 1'b0;
        bus.iTxError = 1'b0;
        bus.iRxData  = 8'h00;
        bus.iRxValid = 1'b0;
        iReset       = 1'b1;
        step(3);
        check_reset_outputs("reset");
        iReset = 1'b0;
        step();

        // Enable request with clean acknowledge; send appears in the 2nd cycle.
        bus.iEnable = 1'b1;
        bus.iStart  = 1'b1;
        check("t1_no_send_edge_cycle", bus.oTxSend, 1'b0);
        step();
        check("t1_send_latency", bus.oTxSend, 1'b1);
        check("t1_cmd", bus.oTxData, CMD_ENABLE);
        check("t1_busy", bus.oBusy, 1'b1);
        bus.iStart = 1'b0;
        step();
        pulse_tx(1'b1, 1'b0);
        step(3);
        rx_byte(RSP_ACK);
        check("t1_done", bus.oDone, 1'b1);
        step();
        check("t1_done_single", bus.oDone, 1'b0);
        check("t1_mouse", bus.oMouseEnabled, 1'b1);
        check("t1_idle", bus.oBusy, 1'b0);

        // Level held for 50 cycles yields a single disable command.
        s0 = n_send;
        bus.iEnable = 1'b0;
        bus.iStart  = 1'b1;
        step(50);
        bus.iStart  = 1'b0;
        check("t2_one_send", n_send - s0, 1);
        check("t2_cmd", bus.oTxData, CMD_DISABLE);
        pulse_tx(1'b1, 1'b0);
        rx_byte(RSP_ACK);
        wait_result(res);
        check("t2_result", res, 1);
        step(5);
        check("t2_mouse", bus.oMouseEnabled, 1'b0);
        check("t2_no_extra_send", n_send - s0, 1);
        check("t2_idle", bus.oBusy, 1'b0);

        // Two resend requests, then acknowledge.
        s0 = n_send;
        e0 = n_err;
        start_req(1'b1);
        send_and_txdone("t3_a1", CMD_ENABLE);
        rx_byte(RSP_RESEND);
        send_and_txdone("t3_a2", CMD_ENABLE);
        rx_byte(RSP_RESEND);
        send_and_txdone("t3_a3", CMD_ENABLE);
        rx_byte(RSP_ACK);
        wait_result(res);
        check("t3_result", res, 1);
        step();
        check("t3_sends", n_send - s0, 3);
        check("t3_no_error", n_err - e0, 0);
        check("t3_mouse", bus.oMouseEnabled, 1'b1);

        // Silent mouse: 1 + MAX_RETRIES sends, each after a full ack window.
        s0 = n_send;
        d0 = n_done;
        start_req(1'b0);
        send_and_txdone("t4_a1", CMD_DISABLE);
        for (int a = 2; a <= MAX_RETRIES + 1; a++) begin
            wait_send($sformatf("t4_a%0d_send", a));
            check($sformatf("t4_a%0d_cmd", a), bus.oTxData, CMD_DISABLE);
            step();
            // WAIT_ACK spans ACK_TIMEOUT cycles between the done strobe and SEND.
            check($sformatf("t4_a%0d_gap", a), send_cyc - txdone_cyc, ACK_TIMEOUT + 1);
            pulse_tx(1'b1, 1'b0);
        end
        wait_result(res);
        check("t4_result", res, 2);
        step();
        check("t4_sends", n_send - s0, MAX_RETRIES + 1);
        check("t4_no_done", n_done - d0, 0);
        check("t4_mouse_unchanged", bus.oMouseEnabled, 1'b1);

        // Stray bytes ignored; request during WAIT_ACK is queued behind the ack.
        start_req(1'b0);
        send_and_txdone("t5_a1", CMD_DISABLE);
        rx_byte(8'h08);
        rx_byte(8'h00);
        check("t5_stray_busy", bus.oBusy, 1'b1);
        check("t5_stray_no_done", bus.oDone, 1'b0);
        start_req(1'b1);
        rx_byte(RSP_ACK);
        check("t5_done", bus.oDone, 1'b1);
        step();
        check("t5_pending_send", bus.oTxSend, 1'b1);
        check("t5_pending_cmd", bus.oTxData, CMD_ENABLE);
        check("t5_pending_busy", bus.oBusy, 1'b1);
        check("t5_first_mouse", bus.oMouseEnabled, 1'b0);
        step();
        pulse_tx(1'b1, 1'b0);
        rx_byte(RSP_ACK);
        wait_result(res);
        check("t5_result", res, 1);
        step();
        check("t5_mouse", bus.oMouseEnabled, 1'b1);

        // Reset while waiting for the acknowledge.
        d0 = n_done;
        e0 = n_err;
        start_req(1'b0);
        send_and_txdone("t6", CMD_DISABLE);
        step(2);
        iReset = 1'b1;
        step();
        check_reset_outputs("t6_reset");
        iReset = 1'b0;
        step(30);
        check("t6_no_done", n_done - d0, 0);
        check("t6_no_error", n_err - e0, 0);
        check("t6_idle", bus.oBusy, 1'b0);

        // iStart already high when reset releases.
        iReset      = 1'b1;
        bus.iEnable = 1'b1;
        bus.iStart  = 1'b1;
        step(2);
        iReset = 1'b0;
        step();
        check("t7_send", bus.oTxSend, 1'b1);
        check("t7_cmd", bus.oTxData, CMD_ENABLE);
        bus.iStart = 1'b0;
        step();
        pulse_tx(1'b1, 1'b0);
        rx_byte(RSP_ACK);
        wait_result(res);
        check("t7_result", res, 1);
        step();
        check("t7_mouse", bus.oMouseEnabled, 1'b1);

        // Random transactions against an attempt-level outcome model.
        model_mouse = 1'b1;
        for (int t = 0; t < 16; t++) begin
            logic       en;
            logic [7:0] sb;
            int         attempts, outcome, r, strays;
            en       = 1'($urandom_range(0, 1));
            s0       = n_send;
            attempts = 0;
            outcome  = 0;
            start_req(en);
            while (outcome == 0) begin
                attempts++;
                wait_send($sformatf("rand%0d_a%0d_send", t, attempts));
                check($sformatf("rand%0d_a%0d_cmd", t, attempts), bus.oTxData, cmd_for(en));
                step();
                step($urandom_range(0, 3));
                r = $urandom_range(0, 9);
                if (r == 8) begin
                    pulse_tx(1'($urandom_range(0, 1)), 1'b1);
                end else begin
                    pulse_tx(1'b1, 1'b0);
                    strays = $urandom_range(0, 2);
                    for (int k = 0; k < strays; k++) begin
                        sb = 8'($urandom_range(0, 255));
                        if (sb == RSP_ACK || sb == RSP_RESEND || sb == RSP_ERROR) sb = 8'h08;
                        rx_byte(sb);
                    end
                    if (r <= 4)      begin rx_byte(RSP_ACK);   outcome = 1; end
                    else if (r <= 6) rx_byte(RSP_RESEND);
                    else if (r == 9) begin rx_byte(RSP_ERROR); outcome = 2; end
                end
                if (outcome == 0 && attempts > MAX_RETRIES) outcome = 2;
            end
            wait_result(res);
            check($sformatf("rand%0d_result", t), res, outcome);
            if (outcome == 1) model_mouse = en;
            step();
            check($sformatf("rand%0d_sends", t), n_send - s0, attempts);
            check($sformatf("rand%0d_mouse", t), bus.oMouseEnabled, model_mouse);
            check($sformatf("rand%0d_idle", t), bus.oBusy, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
